// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes seen by the vending FSM and
// the coin_acceptor state encoding.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_QUAL,
        ST_HELD,
        ST_JAM
    } ca_state_e;

endpackage

// File: rtl/vm_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, one chain per bit.
module vm_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_reg[gi] <= 1'b0;
                sync_reg[gi] <= 1'b0;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/coin_acceptor.sv
// Coin chute front end: synchronises and debounces the 5/10 rs sensors and
// emits one single-cycle coin code per credited coin, or reject/jam flags.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sense5,
    input  logic       sense10,
    input  logic       inhibit,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam
);

    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEB_M1  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] JAM_C   = CW'(JAM_CYCLES);

    logic [1:0]    sync_q;
    logic          s5;
    logic          s10;
    ca_state_e     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_inc;
    logic          kind_reg;   // 1 = 10 rs coin latched
    logic [1:0]    coin_reg;
    logic          reject_reg;
    logic          jam_reg;
    logic          lat_hi;
    logic          oth_hi;

    vm_sync2 #(.W(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({sense10, sense5}),
        .q     (sync_q)
    );

    assign s5      = sync_q[0];
    assign s10     = sync_q[1];
    assign lat_hi  = kind_reg ? s10 : s5;
    assign oth_hi  = kind_reg ? s5  : s10;
    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_CLEAR;
            cnt_reg    <= '0;
            kind_reg   <= 1'b0;
            coin_reg   <= COIN_NONE;
            reject_reg <= 1'b0;
            jam_reg    <= 1'b0;
        end else begin
            coin_reg   <= COIN_NONE;
            reject_reg <= 1'b0;
            case (state_reg)
                ST_CLEAR: begin
                    if (s5 || s10) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_M1) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (s5 && s10) begin
                        reject_reg <= 1'b1;
                        state_reg  <= ST_CLEAR;
                    end else if (s5 || s10) begin
                        if (inhibit) begin
                            reject_reg <= 1'b1;
                            state_reg  <= ST_CLEAR;
                        end else begin
                            kind_reg  <= s10;
                            cnt_reg   <= CNT_ONE;
                            state_reg <= ST_QUAL;
                        end
                    end
                end
                ST_QUAL: begin
                    // A second sensor outranks a dropout of the latched one.
                    if (oth_hi) begin
                        reject_reg <= 1'b1;
                        cnt_reg    <= '0;
                        state_reg  <= ST_CLEAR;
                    end else if (!lat_hi) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_reg == DEB_M1) begin
                            state_reg <= ST_HELD;
                        end
                    end
                end
                ST_HELD: begin
                    if (lat_hi && oth_hi) begin
                        reject_reg <= 1'b1;
                        cnt_reg    <= '0;
                        state_reg  <= ST_CLEAR;
                    end else if (!lat_hi) begin
                        coin_reg  <= kind_reg ? COIN_10 : COIN_5;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == JAM_C) begin
                        jam_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_JAM;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ST_JAM: begin
                    if (s5 || s10) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_M1) begin
                        jam_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    jam_reg   <= 1'b0;
                    state_reg <= ST_CLEAR;
                end
            endcase
        end
    end

    assign coin   = coin_reg;
    assign reject = reject_reg;
    assign jam    = jam_reg;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage of the vending machine. Converts two raw, asynchronous coin-chute sensor lines (5 rs and 10 rs) into the 2-bit coin code that the vending FSM samples every clock: 00 = none, 01 = 5 rs, 10 = 10 rs. The block synchronises, debounces and width-qualifies each coin, then emits exactly one single-cycle code per valid coin. Invalid events (simultaneous sensors, inhibited insertion, jams) produce flags and never produce a code.

## Interface
- `DEB_CYCLES`, default 4: consecutive synchronised-high cycles needed to qualify a coin. Must be ≥ 2.
- `JAM_CYCLES`, default 1000: cycles from entering QUAL after which a still-present coin is declared jammed. Must be > `DEB_CYCLES`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sense5` in 1: raw 5 rs chute sensor, asynchronous, active-high.
- `sense10` in 1: raw 10 rs chute sensor, asynchronous, active-high.
- `inhibit` in 1: when high, new coins are rejected rather than credited.
- `coin` out 2: coin code to the vending FSM. Nonzero for exactly one cycle per credited coin.
- `reject` out 1: one-cycle pulse for a rejected coin.
- `jam` out 1: level, high while in JAM.

## Operation
- Both sense lines pass through a 2-flop synchroniser, giving `s5` and `s10`. All FSM decisions use only `s5` and `s10`.
- Reset values: state CLEAR, counter 0, synchroniser flops 0, `coin` = 00, `reject` = 0, `jam` = 0.
- The FSM has states CLEAR, IDLE, QUAL, HELD, JAM. It uses one counter `cnt` of width $clog2(JAM_CYCLES+1), which saturates.
- **CLEAR**
  - `cnt` counts consecutive cycles with both `s5` and `s10` low. Any high sample resets `cnt` to 0.
  - When `cnt` reaches `DEB_CYCLES`, go to IDLE.
  - Because reset enters CLEAR, a coin held across reset is never credited.
- **IDLE**
  - Exactly one of `s5`/`s10` high and `inhibit` low: latch the coin kind, set `cnt` = 1, go to QUAL.
  - Exactly one high and `inhibit` high: pulse `reject`, go to CLEAR.
  - Both high: pulse `reject`, go to CLEAR.
- **QUAL**
  - Latched sensor high and other sensor low: increment `cnt`. When `cnt` reaches `DEB_CYCLES`, go to HELD.
  - Latched sensor drops before that: treat as a glitch. Go to IDLE with no output and no flag.
  - Other sensor rises: pulse `reject`, go to CLEAR. This rule has priority over the drop rule.
- **HELD**
  - `cnt` keeps incrementing.
  - Latched sensor low: register `coin` = latched code for one cycle, go to IDLE. Credit happens on coin release.
  - Other sensor rises while the latched one is still high: pulse `reject`, go to CLEAR, no credit.
  - `cnt` reaches `JAM_CYCLES` with the sensor still high: go to JAM.
- **JAM**
  - `jam` = 1. `cnt` counts consecutive both-low cycles.
  - When that count reaches `DEB_CYCLES`, go to IDLE and drop `jam`.
  - No code and no `reject` are emitted for a jammed coin.
- `inhibit` is sampled only in IDLE. A coin already in QUAL or HELD completes normally.
- `coin` is never 11. `coin` and `reject` are never high in the same cycle. All outputs are registered.

## Timing
- Synchroniser latency is 2 cycles from the first clock edge that samples a raw change.
- Credit: `coin` is valid in the cycle after the edge at which HELD sees `s` low. That is 3 edges after the raw falling edge is first sampled, and it lasts exactly 1 cycle.
- Minimum accepted pulse: `DEB_CYCLES` synchronised cycles. A pulse of `DEB_CYCLES`−1 cycles is dropped.
- `reject` asserts the cycle after the offending sample and lasts 1 cycle.
- Back-to-back coins: after a credit, the FSM is in IDLE and can accept a new rising sample on the very next cycle.
- Asynchronous `rst_n` assertion mid-coin clears all outputs immediately. A pending credit is lost.

## Structure
- Shared package `vm_pkg` holds:
  - coin-code constants `COIN_NONE` = 2'b00, `COIN_5` = 2'b01, `COIN_10` = 2'b10, shared with the vending FSM;
  - the `coin_acceptor` state enum.
- Sub-module `vm_sync2`: a parameterised-width 2-flop synchroniser with async active-low reset, instantiated once at width 2.

## Test plan
1. Reset, then hold both sensors low for 4 cycles. Raise `sense5` for 10 cycles, then drop it -> one `coin` = 01 pulse, 3 cycles after the drop; `reject` and `jam` stay 0.
2. `sense10` glitch high for 3 synchronised cycles (`DEB_CYCLES` = 4) -> no `coin`, no `reject`. Then a 4-cycle pulse -> `coin` = 10 once.
3. `sense5` high, and `sense10` rises 6 cycles later -> `reject` pulse, no `coin`. The next `coin` appears only after a release, 4 both-low cycles, and a new coin.
4. `inhibit` = 1 in IDLE while `sense10` is inserted -> `reject` pulse, `coin` stays 00. Raising `inhibit` mid-HELD on a 5 rs coin -> still credits 01.
5. `JAM_CYCLES` = 20, `sense5` held 30 cycles -> `jam` rises 20 cycles after QUAL entry. After release plus 4 low cycles, `jam` = 0, with no `coin` and no `reject`.
6. `rst_n` pulsed low while `sense10` is in HELD and the sensor is still high after reset -> no credit. The block waits for 4 both-low cycles, then accepts the next coin normally.
